mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data and address width.
REQ-002 Parameter STARVE_MAX, default 4, maximum consecutive data grants while instruction request waits.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles in an access state without m_ready.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  fetch request; held with i_addr stable until i_ack.
REQ-007 i_addr  in  DATA_W  fetch byte address.
REQ-008 i_rdata  out  DATA_W  fetched word, registered.
REQ-009 i_ack  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  load/store request; held with d_we/d_addr/d_wdata stable until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  DATA_W  data byte address.
REQ-013 d_wdata  in  DATA_W  store data.
REQ-014 d_rdata  out  DATA_W  load word, registered.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 m_req  out  1  memory access request, registered.
REQ-017 m_we  out  1  memory write enable, registered.
REQ-018 m_addr  out  DATA_W  memory address, registered.
REQ-019 m_wdata  out  DATA_W  memory write data, registered.
REQ-020 m_rdata  in  DATA_W  memory read data, valid when m_ready=1.
REQ-021 m_ready  in  1  memory completion, sampled only while m_req=1.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 States: IDLE, I_ACC, D_ACC, RESP.
REQ-024 IDLE: if no request, stay; if one request, grant it; if both requesters, grant D unless starve_cnt==STARVE_MAX, then grant I.
REQ-025 Grant I: next state I_ACC; on the same edge, load m_req=1, m_we=0, m_addr=i_addr.
REQ-026 Grant D: next state D_ACC; on the same edge, load m_req=1, m_we=d_we, m_addr=d_addr, m_wdata=d_wdata.
REQ-027 In x_ACC, m_req/m_we/m_addr/m_wdata stay constant until m_ready=1.
REQ-028 On m_ready=1 in x_ACC: clear m_req and m_we; capture m_rdata into i_rdata (I) or d_rdata (D load only); go to RESP.
REQ-029 RESP: assert exactly the granted ack for one cycle; next state IDLE.
REQ-030 The requester drops req on the edge where ack is sampled; IDLE never sees a stale req.
REQ-031 Minimum latency: req in cycle 0, m_req in cycle 1, m_ready in cycle 1, ack in cycle 2. Back-to-back throughput is 3 cycles per access.
REQ-032 Store: d_rdata unchanged; d_ack still pulses.
REQ-033 starve_cnt, saturating at STARVE_MAX:
  - D grant with i_req=1: increment.
  - Any I grant: clear.
  - D grant with i_req=0: clear.
REQ-034 Timeout: in x_ACC, tmo_cnt increments each cycle while m_ready=0.
REQ-035 When tmo_cnt reaches TIMEOUT:
  - clear m_req;
  - set err=1;
  - leave the granted rdata unchanged;
  - go to RESP, so the ack still pulses.
REQ-036 tmo_cnt clears on entry to any x_ACC state.
REQ-037 m_ready=1 while m_req=0 is ignored.
REQ-038 The granted request is never preempted; the other request waits in IDLE arbitration.

Reset
REQ-039 rst_n low immediately forces:
  - state = IDLE;
  - m_req, m_we, i_ack, d_ack, err = 0;
  - m_addr, m_wdata, i_rdata, d_rdata = 0;
  - starve_cnt, tmo_cnt = 0.
REQ-040 Reset mid-access abandons the access; no ack is issued for it.
REQ-041 err clears only by reset.

Structure
REQ-042 Shared package mem_arb_pkg holds DATA_W, the state encoding (IDLE=0, I_ACC=1, D_ACC=2, RESP=3) and the default STARVE_MAX/TIMEOUT.
REQ-043 Single module; no sub-module.

Verification
REQ-044 Lone fetch: i_req, i_addr=0x40, m_ready=1 in the first m_req cycle, m_rdata=0x20080005 -> m_addr=0x40, m_we=0, i_ack in cycle 2, i_rdata=0x20080005.
REQ-045 Collision: i_req and d_req (load 0x100) in the same cycle -> D granted first; I granted in the IDLE after d_ack; starve_cnt=1 then 0.
REQ-046 Starvation: i_req held while d_req is re-asserted continuously with STARVE_MAX=4 -> after 4 D grants, the 5th grant goes to I.
REQ-047 Store with wait states: d_we=1, d_addr=0x80, d_wdata=0xCAFEF00D, m_ready after 3 cycles -> m_* stable for 3 cycles, d_ack once, d_rdata unchanged.
REQ-048 Timeout: TIMEOUT=8, m_ready held 0 -> m_req drops after 8 cycles, err=1, ack pulses once, err stays 1.
REQ-049 Reset in D_ACC -> all outputs 0 asynchronously, no d_ack, and a fresh request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the default parameter values and the FSM state encoding so
// the RTL and anything else observing the arbiter use one definition.
package mem_arb_pkg;

  localparam int DEF_DATA_W     = 32;   // data and address width
  localparam int DEF_STARVE_MAX = 4;    // D grants allowed while I waits
  localparam int DEF_TIMEOUT    = 255;  // access cycles without m_ready

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: a fetch port (i_*) and a load/store port
// (d_*) share one memory port (m_*). Data wins collisions unless the
// fetch side has been passed over STARVE_MAX times in a row. Each access
// is IDLE -> x_ACC -> RESP, with the ack pulsing during RESP. An access
// that sees no m_ready for TIMEOUT cycles is abandoned, sets sticky err
// and still acks so the requester never hangs.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_req, i_addr                 fetch request (held until i_ack)
//   i_rdata, i_ack                fetched word, completion pulse
//   d_req, d_we, d_addr, d_wdata  load/store request (held until d_ack)
//   d_rdata, d_ack                load word, completion pulse
//   m_req, m_we, m_addr, m_wdata  registered memory request
//   m_rdata, m_ready              memory response
//   err                           sticky timeout flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  // Timeout fires on the cycle whose increment would reach TIMEOUT,
  // so m_req is held for exactly TIMEOUT cycles.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  arb_state_t    state, state_d;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          gnt_i, gnt_d, acc_done, tmo_hit, in_acc;

  assign in_acc = (state == I_ACC) || (state == D_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // m_req is always 1 inside x_ACC, so m_ready is only ever looked at
  // while a request is outstanding.
  always_comb begin
    state_d  = state;
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    acc_done = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(i_req && starve_cnt == STARVE_TOP)) begin
          gnt_d   = 1'b1;
          state_d = D_ACC;
        end else if (i_req) begin
          gnt_i   = 1'b1;
          state_d = I_ACC;
        end
      end
      I_ACC, D_ACC: begin
        if (m_ready) begin
          acc_done = 1'b1;
          state_d  = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      if (gnt_i) begin
        m_req      <= 1'b1;
        m_we       <= 1'b0;
        m_addr     <= i_addr;
        starve_cnt <= '0;
        tmo_cnt    <= '0;
      end

      if (gnt_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        tmo_cnt <= '0;
        // Count only grants that actually made a waiting fetch wait.
        if (!i_req)                         starve_cnt <= '0;
        else if (starve_cnt != STARVE_TOP)  starve_cnt <= starve_cnt + 1'b1;
      end

      if (acc_done || tmo_hit) begin
        m_req <= 1'b0;
        i_ack <= (state == I_ACC);
        d_ack <= (state == D_ACC);
      end

      if (acc_done) begin
        m_we <= 1'b0;
        if (state == I_ACC) i_rdata <= m_rdata;
        else if (!m_we)     d_rdata <= m_rdata;
      end

      if (tmo_hit) err <= 1'b1;

      if (in_acc && !m_ready && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule
